dircc_avalon_st_arbiter: RTL and testbench

DIRCC_AVALON_ST_ARBITER -- requirements
Module: dircc_avalon_st_arbiter

---
 rtl/dircc_avalon_st_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dircc_avalon_st_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dircc_avalon_st_arbiter.sv
// dircc_avalon_st_arbiter
//   Packet-level round-robin arbiter that merges NUM_INPUTS Avalon-ST sources
//   onto one Avalon-ST sink. A source is granted only when it presents a
//   start-of-packet beat, and it keeps the sink until its end-of-packet beat
//   transfers. Beats that arrive without a start-of-packet while the arbiter is
//   idle are drained and counted as errors. A small status port exposes the
//   grant, packet and error counters.
//
// Ports
//   clk, reset                       single clock, synchronous active-high reset
//   in_data/in_empty                 per-source payload, source i in slice i
//   in_valid/in_startofpacket/
//   in_endofpacket                   per-source qualifiers
//   in_ready                         per-source backpressure
//   out_data/out_empty/out_valid/
//   out_startofpacket/out_endofpacket shared sink side
//   out_ready                        sink backpressure
//   address, read_n                  status register select, active-low read
//   readdata                         registered status read data
module dircc_avalon_st_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*2-1:0]          in_empty,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_startofpacket,
  input  logic [NUM_INPUTS-1:0]            in_endofpacket,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [1:0]                       out_empty,
  output logic                             out_valid,
  output logic                             out_startofpacket,
  output logic                             out_endofpacket,
  input  logic                             out_ready,
  input  logic [1:0]                       address,
  input  logic                             read_n,
  output logic [15:0]                      readdata
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [2:0]      grant, grant_nxt;
  logic [2:0]      rr_ptr, rr_ptr_nxt;
  logic            first_beat, first_beat_nxt;

  logic            sop_found, orphan_found;
  logic [2:0]      sop_pick, orphan_pick;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]      sel_empty;
  logic            sel_valid, sel_sop, sel_eop;

  logic            xfer, eop_xfer, err_inc;

  logic [15:0]     pkt_count, err_count;
  logic            err_sticky;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search for a packet start: first look at indices from rr_ptr
  // upward, then wrap around to the low indices.
  always_comb begin
    sop_found = 1'b0;
    sop_pick  = 3'd0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (!sop_found && (j >= int'(rr_ptr)) && in_valid[j] && in_startofpacket[j]) begin
        sop_found = 1'b1;
        sop_pick  = 3'(j);
      end
    end
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (!sop_found && in_valid[j] && in_startofpacket[j]) begin
        sop_found = 1'b1;
        sop_pick  = 3'(j);
      end
    end
  end

  // Lowest-index source holding a beat that is not a packet start.
  always_comb begin
    orphan_found = 1'b0;
    orphan_pick  = 3'd0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (!orphan_found && in_valid[j] && !in_startofpacket[j]) begin
        orphan_found = 1'b1;
        orphan_pick  = 3'(j);
      end
    end
  end

  // Granted-source mux.
  always_comb begin
    sel_data  = '0;
    sel_empty = 2'b00;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (grant == 3'(j)) begin
        sel_data  = in_data[j*DATA_WIDTH +: DATA_WIDTH];
        sel_empty = in_empty[j*2 +: 2];
        sel_valid = in_valid[j];
        sel_sop   = in_startofpacket[j];
        sel_eop   = in_endofpacket[j];
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    grant_nxt         = grant;
    rr_ptr_nxt        = rr_ptr;
    first_beat_nxt    = first_beat;
    in_ready          = '0;
    out_data          = '0;
    out_empty         = 2'b00;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    xfer              = 1'b0;
    eop_xfer          = 1'b0;
    err_inc           = 1'b0;
    case (state)
      IDLE: begin
        // Draining an orphan and granting another source are independent.
        if (orphan_found) begin
          for (int j = 0; j < NUM_INPUTS; j++) begin
            if (orphan_pick == 3'(j)) in_ready[j] = 1'b1;
          end
          err_inc = 1'b1;
        end
        if (sop_found) begin
          state_nxt      = LOCKED;
          grant_nxt      = sop_pick;
          first_beat_nxt = 1'b1;
        end
      end
      LOCKED: begin
        out_data          = sel_data;
        out_empty         = sel_empty;
        out_valid         = sel_valid;
        out_startofpacket = sel_sop;
        out_endofpacket   = sel_eop;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          if (grant == 3'(j)) in_ready[j] = out_ready;
        end
        xfer = sel_valid & out_ready;
        if (xfer) begin
          first_beat_nxt = 1'b0;
          // A repeated start-of-packet inside a packet is flagged but forwarded.
          if (sel_sop && !first_beat) err_inc = 1'b1;
          if (sel_eop) begin
            eop_xfer   = 1'b1;
            state_nxt  = IDLE;
            rr_ptr_nxt = (grant == 3'(NUM_INPUTS - 1)) ? 3'd0 : grant + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 3'd0;
      rr_ptr     <= 3'd0;
      first_beat <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      first_beat <= first_beat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count  <= 16'h0000;
      err_count  <= 16'h0000;
      err_sticky <= 1'b0;
    end else begin
      if (eop_xfer) pkt_count <= sat_inc(pkt_count);
      if (err_inc) begin
        err_count  <= sat_inc(err_count);
        err_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 16'h0000;
    end else if (!read_n) begin
      case (address)
        2'd0:    readdata <= {err_sticky, 11'b0, (state == LOCKED), grant};
        2'd1:    readdata <= pkt_count;
        2'd2:    readdata <= err_count;
        default: readdata <= {13'b0, rr_ptr};
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_avalon_st_arbiter.sv
// Testbench for dircc_avalon_st_arbiter: per-source beat queues feed the DUT,
// expected output beats are queued as packets are loaded and compared as the
// sink accepts them.
module tb_dircc_avalon_st_arbiter;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int BW = DW + 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI*DW-1:0]  in_data = '0;
  logic [NI*2-1:0]   in_empty = '0;
  logic [NI-1:0]     in_valid = '0;
  logic [NI-1:0]     in_startofpacket = '0;
  logic [NI-1:0]     in_endofpacket = '0;
  logic [NI-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_empty;
  logic              out_valid;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic              out_ready = 1'b1;
  logic [1:0]        address = 2'd0;
  logic              read_n = 1'b1;
  logic [15:0]       readdata;

  dircc_avalon_st_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_ready(in_ready),
    .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_ready(out_ready),
    .address(address), .read_n(read_n), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Beat layout: {data, empty, sop, eop}
  logic [BW-1:0] smem [NI][64];
  int            srd [NI];
  int            swr [NI];
  logic [BW-1:0] expq [$];
  int            out_cyc [64];
  int            n_out;
  int            cyc;
  int            rdy_cnt [NI];
  int            ov_cnt;
  logic          force_orphan = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NI; i++) begin
      logic [BW-1:0] b;
      b = '0;
      in_valid[i] = 1'b0;
      if (force_orphan && i == 0) begin
        in_valid[i] = 1'b1;
      end else if (srd[i] < swr[i]) begin
        b = smem[i][srd[i]];
        in_valid[i] = 1'b1;
      end
      in_data[i*DW +: DW]   = b[BW-1 -: DW];
      in_empty[i*2 +: 2]    = b[3:2];
      in_startofpacket[i]   = b[1];
      in_endofpacket[i]     = b[0];
    end
  endtask

  task automatic cycle();
    logic [NI-1:0] fire;
    logic [BW-1:0] got;
    logic [BW-1:0] e;
    drive_inputs();
    @(negedge clk);
    fire = '0;
    if (!reset) begin
      fire = in_valid & in_ready;
      for (int i = 0; i < NI; i++) if (in_ready[i]) rdy_cnt[i]++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        got = {out_data, out_empty, out_startofpacket, out_endofpacket};
        check_eq("beat_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check_eq("out_beat", 64'(got), 64'(e));
        end
        if (n_out < 64) out_cyc[n_out] = cyc;
        n_out++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) if (fire[i] && srd[i] < swr[i]) srd[i]++;
    drive_inputs();
  endtask

  task automatic clear_stats();
    n_out = 0;
    cyc = 0;
    ov_cnt = 0;
    for (int i = 0; i < NI; i++) rdy_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      srd[i] = 0;
      swr[i] = 0;
    end
    expq.delete();
    force_orphan = 1'b0;
    out_ready = 1'b1;
    read_n = 1'b1;
    address = 2'd0;
    cycle();
    cycle();
    reset = 1'b0;
    drive_inputs();
    clear_stats();
  endtask

  task automatic load_beat(input int src, input logic [DW-1:0] d, input logic [1:0] emp,
                           input logic sop, input logic eop, input logic push);
    logic [BW-1:0] b;
    b = {d, emp, sop, eop};
    smem[src][swr[src]] = b;
    swr[src]++;
    if (push) expq.push_back(b);
  endtask

  task automatic load_pkt(input int src, input int n, input int id);
    for (int b = 0; b < n; b++)
      load_beat(src, {4'(src), 12'(id), 16'(b)}, (b == n - 1) ? 2'(id) : 2'b00,
                b == 0, b == n - 1, 1'b1);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [15:0] exp, input string tag);
    address = a;
    read_n = 1'b0;
    cycle();
    read_n = 1'b1;
    check_eq(tag, 64'(readdata), 64'(exp));
  endtask

  task automatic wait_outs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin
      cycle();
      k++;
    end
    check_eq(tag, 64'(n_out >= n), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      srd[i] = 0;
      swr[i] = 0;
    end
    clear_stats();

    // Reset state
    do_reset();
    check_eq("rst_readdata", 64'(readdata), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h0);

    // Two competing 3-beat packets from reset
    load_pkt(0, 3, 1);
    load_pkt(2, 3, 2);
    wait_outs(6, 40, "t030_done");
    check_eq("t030_first_latency", 64'(out_cyc[0]), 64'd1);
    check_eq("t030_intra_gap", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
    check_eq("t030_idle_gap", 64'(out_cyc[3] - out_cyc[2]), 64'd2);
    do_read(2'd1, 16'd2, "t030_pkt_count");
    do_read(2'd3, 16'd3, "t030_rr_ptr");
    check_eq("t030_sb_empty", 64'(expq.size()), 64'd0);

    // Four sources streaming single-beat packets
    do_reset();
    load_pkt(0, 1, 10);
    load_pkt(1, 1, 11);
    load_pkt(2, 1, 12);
    load_pkt(3, 1, 13);
    load_pkt(0, 1, 14);
    wait_outs(5, 40, "t031_done");
    for (int k = 1; k < 5; k++)
      check_eq("t031_beat_gap", 64'(out_cyc[k] - out_cyc[k-1]), 64'd2);
    do_read(2'd1, 16'd5, "t031_pkt_count");
    do_read(2'd2, 16'd0, "t031_err_count");
    check_eq("t031_sb_empty", 64'(expq.size()), 64'd0);

    // Sink stall mid-packet while another source waits
    do_reset();
    load_pkt(1, 4, 3);
    load_pkt(3, 2, 4);
    wait_outs(2, 20, "t032_first_beats");
    out_ready = 1'b0;
    repeat (4) cycle();
    do_read(2'd0, 16'h0009, "t032_status_locked");
    check_eq("t032_stall_hold", 64'(n_out), 64'd2);
    out_ready = 1'b1;
    wait_outs(4, 20, "t032_src1_done");
    check_eq("t032_rdy3_low", 64'(rdy_cnt[3]), 64'd0);
    wait_outs(6, 20, "t032_src3_done");
    check_eq("t032_sb_empty", 64'(expq.size()), 64'd0);

    // Orphan beat drained in idle
    do_reset();
    load_beat(2, 32'hDEAD0002, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    check_eq("t033_rdy2_once", 64'(rdy_cnt[2]), 64'd1);
    check_eq("t033_no_output", 64'(ov_cnt), 64'd0);
    check_eq("t033_consumed", 64'(srd[2]), 64'd1);
    do_read(2'd0, 16'h8000, "t033_status");
    do_read(2'd2, 16'd1, "t033_err_count");

    // Drain and grant in the same idle cycle
    do_reset();
    load_beat(1, 32'hBEEF0001, 2'b00, 1'b0, 1'b0, 1'b0);
    load_pkt(2, 3, 5);
    wait_outs(3, 20, "t021_done");
    check_eq("t021_rdy1_once", 64'(rdy_cnt[1]), 64'd1);
    check_eq("t021_grant_latency", 64'(out_cyc[0]), 64'd1);
    do_read(2'd2, 16'd1, "t021_err_count");
    check_eq("t021_sb_empty", 64'(expq.size()), 64'd0);

    // Repeated start-of-packet inside a packet
    do_reset();
    load_beat(0, 32'h00A00000, 2'b00, 1'b1, 1'b0, 1'b1);
    load_beat(0, 32'h00A00001, 2'b00, 1'b1, 1'b0, 1'b1);
    load_beat(0, 32'h00A00002, 2'b11, 1'b0, 1'b1, 1'b1);
    wait_outs(3, 20, "t022_done");
    do_read(2'd2, 16'd1, "t022_err_count");
    do_read(2'd0, 16'h8000, "t022_status");
    do_read(2'd1, 16'd1, "t022_pkt_count");

    // Reset in the middle of a packet
    do_reset();
    load_pkt(1, 1, 6);
    wait_outs(1, 10, "t035_pre_pkt");
    do_read(2'd1, 16'd1, "t035_pre_count");
    load_pkt(0, 4, 7);
    wait_outs(2, 20, "t035_beat1");
    check_eq("t035_beat2_presented", 64'(out_valid), 64'd1);
    do_reset();
    check_eq("t035_out_valid", 64'(out_valid), 64'd0);
    check_eq("t035_in_ready", 64'(in_ready), 64'd0);
    check_eq("t035_readdata", 64'(readdata), 64'd0);
    do_read(2'd0, 16'h0000, "t035_status");
    do_read(2'd1, 16'h0000, "t035_pkt_count");
    do_read(2'd2, 16'h0000, "t035_err_count");
    do_read(2'd3, 16'h0000, "t035_rr_ptr");
    check_eq("t035_no_output", 64'(ov_cnt), 64'd0);

    // Error counter saturation via continuous orphan beats
    do_reset();
    force_orphan = 1'b1;
    repeat (100) cycle();
    force_orphan = 1'b0;
    do_read(2'd2, 16'd100, "sat_err_mid");
    force_orphan = 1'b1;
    repeat (65500) cycle();
    force_orphan = 1'b0;
    do_read(2'd2, 16'hFFFF, "sat_err_full");
    do_read(2'd0, 16'h8000, "sat_status");
    check_eq("sat_no_output", 64'(ov_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
